// File: rtl/wb_hram_arbiter.sv
// Two-master Wishbone arbiter in front of the HyperRAM controller data port.
// Registered grant, whole-cycle ownership, starvation override and an ack watchdog.
module wb_hram_arbiter #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned STREAM_PRIO = 1,
    parameter int unsigned MAX_WAIT    = 64,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic              m0_we_i,
    input  logic [2:0]        m0_cti_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic              m1_we_i,
    input  logic [2:0]        m1_cti_i,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic              s_we_o,
    output logic [2:0]        s_cti_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,
    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN0  = 2'd1;
    localparam logic [1:0] OWN1  = 2'd2;
    localparam logic [1:0] ABORT = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic          abort_q, abort_d;
    logic [TW-1:0] wd_q, wd_d;
    logic [CW-1:0] st0_q, st0_d, st1_q, st1_d;

    logic own_cyc;
    logic own_stb;
    logic starved0;
    logic starved1;

    // State and bookkeeping registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            abort_q <= 1'b0;
            wd_q    <= '0;
            st0_q   <= '0;
            st1_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            abort_q <= abort_d;
            wd_q    <= wd_d;
            st0_q   <= st0_d;
            st1_q   <= st1_d;
        end
    end

    // Arbitration, ownership release, watchdog and starvation counting
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        abort_d  = abort_q;
        wd_d     = wd_q;
        st0_d    = st0_q;
        st1_d    = st1_q;
        own_cyc  = (state_q == OWN1) ? m1_cyc_i : m0_cyc_i;
        own_stb  = (state_q == OWN1) ? m1_stb_i : m0_stb_i;
        starved0 = (st0_q >= CW'(MAX_WAIT));
        starved1 = (st1_q >= CW'(MAX_WAIT));

        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (m0_cyc_i && m1_cyc_i) begin
                    if (starved0)              state_d = OWN0;
                    else if (starved1)         state_d = OWN1;
                    else if (STREAM_PRIO != 0) state_d = OWN1;
                    else if (last_q)           state_d = OWN0;
                    else                       state_d = OWN1;
                end else if (m0_cyc_i) begin
                    state_d = OWN0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    last_d  = (state_q == OWN1);
                    wd_d    = '0;
                end else if (own_stb && !s_ack_i) begin
                    if ((TIMEOUT != 0) && (wd_q == TW'(TIMEOUT - 1))) begin
                        state_d = ABORT;
                        abort_d = (state_q == OWN1);
                        wd_d    = '0;
                    end else begin
                        wd_d = wd_q + TW'(1);
                    end
                end else if (s_ack_i) begin
                    wd_d = '0;
                end
            end
            ABORT: begin
                state_d = IDLE;
                wd_d    = '0;
            end
            default: state_d = IDLE;
        endcase

        // A master's wait count only grows while it asks and someone else holds the port
        if (!m0_cyc_i || (state_q == OWN0) || (state_d == OWN0)) st0_d = '0;
        else if (st0_q < CW'(MAX_WAIT))                          st0_d = st0_q + CW'(1);

        if (!m1_cyc_i || (state_q == OWN1) || (state_d == OWN1)) st1_d = '0;
        else if (st1_q < CW'(MAX_WAIT))                          st1_d = st1_q + CW'(1);
    end

    // Slave-side mux and master return paths, selected by the registered owner
    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cti_o   = 3'b000;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m0_dat_o  = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_dat_o  = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        timeout_o = 1'b0;

        case (state_q)
            OWN0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cti_o  = m0_cti_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
            end
            OWN1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cti_o  = m1_cti_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
            end
            ABORT: begin
                timeout_o = 1'b1;
                if (abort_q) m1_err_o = 1'b1;
                else         m0_err_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign grant_o = {state_q == OWN1, state_q == OWN0};

endmodule
